// File: rtl/uart_req_arb.sv
// Round-robin arbiter granting NREQ requesters one 32-bit UART transaction at a time.
// Optional XFER watchdog enabled by defining UART_ARB_TIMEOUT_EN.
module uart_req_arb #(
  parameter int unsigned NREQ      = 4,
  parameter int unsigned TIMEOUT   = 50000,
  parameter int unsigned CLOSE_CYC = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NREQ-1:0]           req_valid,
  input  logic [NREQ-1:0]           req_dir,
  input  logic [NREQ*32-1:0]        req_wdata,
  output logic [NREQ-1:0]           req_ready,
  output logic [NREQ-1:0]           rsp_valid,
  output logic [31:0]               rsp_rdata,
  output logic                      rsp_err,
  output logic                      busy,
  output logic [$clog2(NREQ)-1:0]   grant_id,
  output logic [2:0]                UaUc_wr_sel,
  output logic [31:0]               UaUc_data_in,
  output logic                      UaUc_data_in_en,
  input  logic                      UcUa_txd_valid,
  input  logic                      UcUa_rxd_ready,
  input  logic [31:0]               UcUa_data_out
);

  localparam int unsigned GW = $clog2(NREQ);

  typedef enum logic [2:0] {IDLE, OPEN, XFER, CLOSE, DONE} state_t;

  state_t          state_q, state_d;
  logic [GW-1:0]   last_q, last_d, win;
  logic            dir_q, dir_d;
  logic [3:0]      ccnt_q, ccnt_d;
  logic            err_q, err_d;
  logic            tx_s1, tx_s2, rx_s1, rx_s2, prev_q;
  logic            flag, done, tout;

  logic [NREQ-1:0] req_ready_d, rsp_valid_d;
  logic [31:0]     rsp_rdata_d, data_in_d;
  logic            rsp_err_d, busy_d, data_in_en_d;
  logic [GW-1:0]   grant_d;
  logic [2:0]      wr_sel_d;

  // prev_q is forced high outside XFER so a flag already high on entry never reads as an edge
  assign flag = dir_q ? tx_s2 : rx_s2;
  assign done = (state_q == XFER) && flag && !prev_q;

`ifdef UART_ARB_TIMEOUT_EN
  logic [15:0] tcnt_q;
  always_ff @(posedge clk) begin
    if (rst || state_q != XFER) tcnt_q <= '0;
    else                        tcnt_q <= tcnt_q + 16'd1;
  end
  assign tout = (state_q == XFER) && (tcnt_q == 16'(TIMEOUT - 1));
`else
  assign tout = 1'b0;
`endif

  always_comb begin
    logic          found;
    logic [GW-1:0] sel;
    win   = '0;
    found = 1'b0;
    for (int unsigned k = 1; k <= NREQ; k++) begin
      sel = GW'((32'(last_q) + k) % NREQ);
      if (!found && req_valid[sel]) begin
        found = 1'b1;
        win   = sel;
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    last_d       = last_q;
    dir_d        = dir_q;
    ccnt_d       = ccnt_q;
    err_d        = err_q;
    req_ready_d  = '0;
    rsp_valid_d  = '0;
    rsp_rdata_d  = rsp_rdata;
    rsp_err_d    = 1'b0;
    grant_d      = grant_id;
    wr_sel_d     = 3'b000;
    data_in_d    = UaUc_data_in;
    data_in_en_d = 1'b0;
    case (state_q)
      IDLE: if (|req_valid) begin
        state_d          = OPEN;
        req_ready_d[win] = 1'b1;
        grant_d          = win;
        dir_d            = req_dir[win];
        data_in_d        = req_wdata[32*win +: 32];
        wr_sel_d         = req_dir[win] ? 3'b100 : 3'b010;
        err_d            = 1'b0;
      end
      OPEN: begin
        state_d      = XFER;
        data_in_en_d = dir_q;
      end
      XFER: begin
        data_in_en_d = dir_q;
        if (done || tout) begin
          state_d      = CLOSE;
          data_in_en_d = 1'b0;
          wr_sel_d     = 3'b001;
          ccnt_d       = 4'(CLOSE_CYC - 1);
          if (done) begin
            if (!dir_q) rsp_rdata_d = UcUa_data_out;
          end else begin
            err_d       = 1'b1;
            rsp_rdata_d = '0;
          end
        end
      end
      CLOSE: begin
        if (ccnt_q == 4'd0) begin
          state_d               = DONE;
          rsp_valid_d[grant_id] = 1'b1;
          rsp_err_d             = err_q;
        end else begin
          ccnt_d   = ccnt_q - 4'd1;
          wr_sel_d = 3'b001;
        end
      end
      DONE: begin
        last_d  = grant_id;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= IDLE;
      last_q          <= GW'(NREQ - 1);
      dir_q           <= 1'b0;
      ccnt_q          <= '0;
      err_q           <= 1'b0;
      tx_s1           <= 1'b0;
      tx_s2           <= 1'b0;
      rx_s1           <= 1'b0;
      rx_s2           <= 1'b0;
      prev_q          <= 1'b0;
      req_ready       <= '0;
      rsp_valid       <= '0;
      rsp_rdata       <= '0;
      rsp_err         <= 1'b0;
      busy            <= 1'b0;
      grant_id        <= '0;
      UaUc_wr_sel     <= 3'b000;
      UaUc_data_in    <= '0;
      UaUc_data_in_en <= 1'b0;
    end else begin
      state_q         <= state_d;
      last_q          <= last_d;
      dir_q           <= dir_d;
      ccnt_q          <= ccnt_d;
      err_q           <= err_d;
      tx_s1           <= UcUa_txd_valid;
      tx_s2           <= tx_s1;
      rx_s1           <= UcUa_rxd_ready;
      rx_s2           <= rx_s1;
      prev_q          <= (state_q == XFER) ? flag : 1'b1;
      req_ready       <= req_ready_d;
      rsp_valid       <= rsp_valid_d;
      rsp_rdata       <= rsp_rdata_d;
      rsp_err         <= rsp_err_d;
      busy            <= busy_d;
      grant_id        <= grant_d;
      UaUc_wr_sel     <= wr_sel_d;
      UaUc_data_in    <= data_in_d;
      UaUc_data_in_en <= data_in_en_d;
    end
  end

endmodule

// File: tb/tb_uart_req_arb.sv
// Self-checking bench for uart_req_arb: directed vector table, round-robin/reset/stale-flag
// sequences, and randomized transactions checked against a transaction-level model.
module tb_uart_req_arb;

  localparam int unsigned NREQ      = 4;
  localparam int unsigned CLOSE_CYC = 2;
  localparam int unsigned TIMEOUT   = 100;

  logic              clk = 1'b0;
  logic              rst;
  logic [NREQ-1:0]   req_valid, req_dir, req_ready, rsp_valid;
  logic [NREQ*32-1:0] req_wdata;
  logic [31:0]       rsp_rdata, data_in, data_out;
  logic              rsp_err, busy, data_in_en, txd, rxd;
  logic [1:0]        grant_id;
  logic [2:0]        wr_sel;

  int unsigned nvec = 0;
  int unsigned nerr = 0;
  int unsigned m_last;
  logic [31:0] m_rdata;

  uart_req_arb #(.NREQ(NREQ), .TIMEOUT(TIMEOUT), .CLOSE_CYC(CLOSE_CYC)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_dir(req_dir), .req_wdata(req_wdata),
    .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err), .busy(busy), .grant_id(grant_id),
    .UaUc_wr_sel(wr_sel), .UaUc_data_in(data_in), .UaUc_data_in_en(data_in_en),
    .UcUa_txd_valid(txd), .UcUa_rxd_ready(rxd), .UcUa_data_out(data_out)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout want completion");
    $fatal(1);
  end

  typedef struct {
    logic [3:0]  mask;
    logic [3:0]  dir;
    logic [31:0] wd;
    logic [31:0] rx;
    int unsigned exp_win;
    logic [31:0] exp_rdata;
  } vec_t;

  vec_t tbl[7];

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  function automatic int unsigned rr_pick(input logic [3:0] mask, input int unsigned last);
    for (int unsigned k = 1; k <= NREQ; k++)
      if (mask[(last + k) % NREQ]) return (last + k) % NREQ;
    return last;
  endfunction

  task automatic chk_reset_outputs();
    chk("rst_req_ready", 32'(req_ready), 32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rsp_rdata", rsp_rdata, 32'd0);
    chk("rst_rsp_err", 32'(rsp_err), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_grant_id", 32'(grant_id), 32'd0);
    chk("rst_wr_sel", 32'(wr_sel), 32'd0);
    chk("rst_data_in", data_in, 32'd0);
    chk("rst_data_in_en", 32'(data_in_en), 32'd0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req_valid = '0;
    txd = 1'b0;
    rxd = 1'b0;
    tick();
    tick();
    chk_reset_outputs();
    rst = 1'b0;
    m_last  = NREQ - 1;
    m_rdata = '0;
  endtask

  // Ends on the first XFER cycle plus dly further cycles.
  task automatic grant_phase(input logic [3:0] mask, input logic [3:0] dir, input logic [31:0] wd,
                             input bit hold, input int unsigned ew, input int unsigned dly);
    int unsigned n = 0;
    req_valid = mask;
    req_dir   = dir;
    for (int i = 0; i < NREQ; i++) req_wdata[32*i +: 32] = wd + 32'(i);
    do begin
      tick();
      n++;
    end while (req_ready == '0 && n < 10);
    chk("grant_req_ready", 32'(req_ready), 32'd1 << ew);
    chk("grant_id", 32'(grant_id), 32'(ew));
    chk("open_wr_sel", 32'(wr_sel), dir[ew] ? 32'h4 : 32'h2);
    chk("open_busy", 32'(busy), 32'd1);
    if (!hold) req_valid = '0;
    tick();
    chk("xfer_wr_sel", 32'(wr_sel), 32'd0);
    chk("xfer_req_ready", 32'(req_ready), 32'd0);
    chk("xfer_data_in_en", 32'(data_in_en), 32'(dir[ew]));
    if (dir[ew]) chk("xfer_data_in", data_in, wd + 32'(ew));
    repeat (dly) begin
      tick();
      chk("xfer_wait_sel", 32'(wr_sel), 32'd0);
    end
  endtask

  task automatic finish_phase(input bit d, input logic [31:0] rx, input int unsigned ew,
                              input logic [31:0] er);
    if (d) begin
      data_out = $urandom;
      txd = 1'b1;
    end else begin
      data_out = rx;
      rxd = 1'b1;
    end
    tick();
    chk("sync1_wr_sel", 32'(wr_sel), 32'd0);
    tick();
    chk("sync2_wr_sel", 32'(wr_sel), 32'd0);
    chk("sync2_data_in_en", 32'(data_in_en), 32'(d));
    tick();
    chk("close_wr_sel", 32'(wr_sel), 32'd1);
    chk("close_data_in_en", 32'(data_in_en), 32'd0);
    repeat (CLOSE_CYC - 1) begin
      tick();
      chk("close_hold_sel", 32'(wr_sel), 32'd1);
    end
    tick();
    chk("done_rsp_valid", 32'(rsp_valid), 32'd1 << ew);
    chk("done_rsp_err", 32'(rsp_err), 32'd0);
    chk("done_rsp_rdata", rsp_rdata, er);
    chk("done_wr_sel", 32'(wr_sel), 32'd0);
    txd = 1'b0;
    rxd = 1'b0;
    tick();
    chk("post_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("post_busy", 32'(busy), 32'd0);
  endtask

  initial begin
    logic [3:0]  mask, dir;
    logic [31:0] wd, rx, er;
    int unsigned ew;
    bit          seen;

    rst = 1'b1;
    req_valid = '0;
    req_dir = '0;
    req_wdata = '0;
    txd = 1'b0;
    rxd = 1'b0;
    data_out = '0;

    tbl[0] = '{4'b0010, 4'b0010, 32'hDEADBEEE, 32'h0,        1, 32'h0};
    tbl[1] = '{4'b1001, 4'b0000, 32'h11110000, 32'hA5A50001, 3, 32'hA5A50001};
    tbl[2] = '{4'b0100, 4'b0000, 32'h22220000, 32'h12345678, 2, 32'h12345678};
    tbl[3] = '{4'b1111, 4'b1111, 32'h33330000, 32'h0,        3, 32'h12345678};
    tbl[4] = '{4'b1111, 4'b1010, 32'h44440000, 32'h55AA55AA, 0, 32'h55AA55AA};
    tbl[5] = '{4'b0110, 4'b0010, 32'h55550000, 32'h0,        1, 32'h55AA55AA};
    tbl[6] = '{4'b0001, 4'b0000, 32'h66660000, 32'h0BADF00D, 0, 32'h0BADF00D};

    do_reset();

    for (int i = 0; i < 7; i++) begin
      grant_phase(tbl[i].mask, tbl[i].dir, tbl[i].wd, 1'b0, tbl[i].exp_win, i % 3);
      finish_phase(tbl[i].dir[tbl[i].exp_win], tbl[i].rx, tbl[i].exp_win, tbl[i].exp_rdata);
      m_last  = tbl[i].exp_win;
      m_rdata = tbl[i].exp_rdata;
    end

    for (int i = 0; i < 40; i++) begin
      mask = 4'($urandom_range(1, 15));
      dir  = 4'($urandom);
      wd   = $urandom;
      rx   = $urandom;
      ew   = rr_pick(mask, m_last);
      er   = dir[ew] ? m_rdata : rx;
      grant_phase(mask, dir, wd, 1'b0, ew, $urandom_range(0, 4));
      finish_phase(dir[ew], rx, ew, er);
      m_last  = ew;
      m_rdata = er;
    end

    // All four requesting continuously: rotation from requester 0
    do_reset();
    for (int j = 0; j < 5; j++) begin
      grant_phase(4'b1111, 4'b1111, 32'(j) << 16, 1'b1, j % NREQ, 0);
      finish_phase(1'b1, 32'h0, j % NREQ, m_rdata);
    end
    req_valid = '0;
    m_last = 0;

    // Stale tx flag already high at XFER entry must not complete the transfer
    txd = 1'b1;
    repeat (3) tick();
    grant_phase(4'b0100, 4'b0100, 32'h77770000, 1'b0, 2, 0);
    repeat (8) begin
      tick();
      chk("stale_wr_sel", 32'(wr_sel), 32'd0);
      chk("stale_rsp_valid", 32'(rsp_valid), 32'd0);
    end
    txd = 1'b0;
    repeat (3) tick();
    finish_phase(1'b1, 32'h0, 2, m_rdata);
    m_last = 2;

    // Reset in the middle of XFER
    grant_phase(4'b0100, 4'b0000, 32'h88880000, 1'b0, 2, 2);
    rst = 1'b1;
    tick();
    chk_reset_outputs();
    rst = 1'b0;
    data_out = 32'hFFFF0000;
    rxd = 1'b1;
    repeat (4) begin
      tick();
      chk("post_rst_rsp_valid", 32'(rsp_valid), 32'd0);
      chk("post_rst_busy", 32'(busy), 32'd0);
    end
    rxd = 1'b0;
    repeat (3) tick();
    m_last  = NREQ - 1;
    m_rdata = '0;
    grant_phase(4'b1000, 4'b0000, 32'h99990000, 1'b0, 3, 1);
    finish_phase(1'b0, 32'hC0FFEE01, 3, 32'hC0FFEE01);
    m_last  = 3;
    m_rdata = 32'hC0FFEE01;

    // rx that never completes
    grant_phase(4'b0001, 4'b0000, 32'hAAAA0000, 1'b0, 0, 0);
`ifdef UART_ARB_TIMEOUT_EN
    repeat (TIMEOUT - 1) tick();
    chk("tout_pre_sel", 32'(wr_sel), 32'd0);
    tick();
    chk("tout_close_sel", 32'(wr_sel), 32'd1);
    repeat (CLOSE_CYC - 1) tick();
    tick();
    chk("tout_rsp_valid", 32'(rsp_valid), 32'd1);
    chk("tout_rsp_err", 32'(rsp_err), 32'd1);
    chk("tout_rsp_rdata", rsp_rdata, 32'd0);
    tick();
    chk("tout_post_busy", 32'(busy), 32'd0);
`else
    seen = 1'b0;
    repeat (1000) begin
      tick();
      if (rsp_valid != '0) seen = 1'b1;
    end
    chk("no_tout_busy", 32'(busy), 32'd1);
    chk("no_tout_rsp", 32'(seen), 32'd0);
    chk("no_tout_wr_sel", 32'(wr_sel), 32'd0);
    do_reset();
`endif

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
